str_match_ctrl: RTL and testbench
=================================

STR_MATCH_CTRL -- requirements
Module: str_match_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, maximum pattern length in bytes (fixed 8 for this release).
REQ-002 SHALL have port clk_50mhz  input  1  single 50 MHz system clock; all logic rising-edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cfg_we  input  1  pattern byte write strobe.
REQ-005 SHALL have port cfg_addr  input  3  pattern byte index 0..7.
REQ-006 SHALL have port cfg_data  input  8  pattern byte (ASCII).
REQ-007 SHALL have port cfg_len  input  4  pattern length, sampled on cfg_commit.
REQ-008 SHALL have port cfg_commit  input  1  arm-request pulse.
REQ-009 SHALL have port disarm  input  1  return-to-idle request.
REQ-010 SHALL have port data  input  8  stream byte.
REQ-011 SHALL have port data_vld  input  1  data qualifier; byte consumed when high.
REQ-012 SHALL have port armed  output  1  high in RUN state.
REQ-013 SHALL have port cfg_err  output  1  sticky invalid-length flag.
REQ-014 SHALL have port match  output  1  one-cycle match pulse.
REQ-015 SHALL have port led  output  1  toggles on every match.
REQ-016 SHALL have port match_cnt  output  8  saturating match count.

Function
REQ-017 SHALL implement two states: IDLE (disarmed) and RUN (matching); match index idx register width 4.
REQ-018 SHALL, in IDLE only, write cfg_data into pattern[cfg_addr] when cfg_we=1; cfg_we in RUN ignored.
REQ-019 SHALL, in IDLE on cfg_commit with 1<=cfg_len<=8, latch len, clear idx, clear cfg_err, enter RUN next cycle.
REQ-020 SHALL, on cfg_commit with cfg_len=0 or >8, stay IDLE and set cfg_err=1 until next valid commit or reset.
REQ-021 SHALL ignore cfg_commit in RUN.
REQ-022 SHALL, on disarm=1 in any state, go/stay IDLE, clear idx; disarm has priority over data_vld and cfg_commit same cycle; match_cnt and led retained.
REQ-023 SHALL, in RUN with data_vld=0, hold idx and all outputs except match (0).
REQ-024 SHALL, in RUN with data_vld=1 and data==pattern[idx]: if idx==len-1, complete match and set idx=0; else idx=idx+1.
REQ-025 SHALL, in RUN with data_vld=1 and data!=pattern[idx]: set idx=1 if data==pattern[0], else idx=0 (no full KMP fallback).
REQ-026 SHALL, on match completion, assert match for exactly the next cycle (latency 1 clock from final byte sample), toggle led, increment match_cnt.
REQ-027 SHALL saturate match_cnt at 255; led and match continue to operate at saturation.
REQ-028 SHALL treat matches as non-overlapping: bytes of a completed match are not reused.
REQ-029 SHALL, with len=1, produce a match on every valid byte equal to pattern[0], including back-to-back cycles.
REQ-030 SHALL drive armed=1 exactly while in RUN.

Reset
REQ-031 SHALL, on rst_n=0, asynchronously force state IDLE, idx=0, len=0, pattern bytes 0x00, armed=0, cfg_err=0, match=0, led=0, match_cnt=0.
REQ-032 SHALL, after reset deassertion, require a new valid cfg_commit before any match is reported.
REQ-033 SHALL, on reset mid-pattern or mid-match pulse, abandon the partial match with no match pulse.

Verification
REQ-034 SHALL cover: load "HELLO", len=5, commit, stream "HEHELLO" one byte/cycle -> one match pulse one cycle after final "O", led 0->1, match_cnt=1.
REQ-035 SHALL cover: stream "HHELLO" and "HELHELLO" -> restart rule gives exactly one match each; stream "hello" -> no match (case-sensitive).
REQ-036 SHALL cover: commit with cfg_len=0 and cfg_len=9 -> armed=0, cfg_err=1; subsequent cfg_len=5 commit -> armed=1, cfg_err=0.
REQ-037 SHALL cover: len=1 pattern "L", stream "LLL" with data_vld gaps -> three match pulses, match_cnt=3, led=1; 260 matches -> match_cnt=255.
REQ-038 SHALL cover: disarm after "HEL", re-commit, stream "LO" -> no match; cfg_we in RUN does not alter pattern.
REQ-039 SHALL cover: rst_n pulsed low after "HELL" -> all outputs zero immediately, no match on following "O".

Source files
------------

// File: rtl/str_match_ctrl.sv
// rtl/str_match_ctrl.sv - streaming byte-pattern matcher with IDLE/RUN control
// Pattern is loaded byte-wise in IDLE, armed by a length commit, then matched against the stream.
module str_match_ctrl #(
  parameter int MAX_LEN = 8
) (
  input  logic       clk_50mhz,
  input  logic       rst_n,
  input  logic       cfg_we,
  input  logic [2:0] cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic [3:0] cfg_len,
  input  logic       cfg_commit,
  input  logic       disarm,
  input  logic [7:0] data,
  input  logic       data_vld,
  output logic       armed,
  output logic       cfg_err,
  output logic       match,
  output logic       led,
  output logic [7:0] match_cnt
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t     state_q;
  logic [3:0] idx_q;
  logic [3:0] len_q;
  logic [7:0] pattern_q [MAX_LEN];
  logic       armed_q;
  logic       cfg_err_q;
  logic       match_q;
  logic       led_q;
  logic [7:0] match_cnt_q;

  logic [7:0] cur_byte;
  logic       hit;
  logic       done;
  logic       len_ok;
  logic [3:0] idx_d;

  always_comb begin
    cur_byte = 8'h00;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (idx_q == 4'(i)) cur_byte = pattern_q[i];
    end
    hit    = (data == cur_byte);
    done   = hit && (idx_q == len_q - 4'd1);
    len_ok = (cfg_len != 4'd0) && (cfg_len <= 4'(MAX_LEN));
    // On a miss only the first pattern byte is retried; no deeper fallback.
    if (hit) idx_d = done ? 4'd0 : idx_q + 4'd1;
    else     idx_d = (data == pattern_q[0]) ? 4'd1 : 4'd0;
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 4'd0;
      len_q       <= 4'd0;
      armed_q     <= 1'b0;
      cfg_err_q   <= 1'b0;
      match_q     <= 1'b0;
      led_q       <= 1'b0;
      match_cnt_q <= 8'd0;
      for (int i = 0; i < MAX_LEN; i++) pattern_q[i] <= 8'h00;
    end else begin
      match_q <= 1'b0;
      if (state_q == S_IDLE && cfg_we) pattern_q[cfg_addr] <= cfg_data;
      if (disarm) begin
        state_q <= S_IDLE;
        armed_q <= 1'b0;
        idx_q   <= 4'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (cfg_commit) begin
              if (len_ok) begin
                len_q     <= cfg_len;
                idx_q     <= 4'd0;
                cfg_err_q <= 1'b0;
                state_q   <= S_RUN;
                armed_q   <= 1'b1;
              end else begin
                cfg_err_q <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (data_vld) begin
              idx_q <= idx_d;
              if (done) begin
                match_q <= 1'b1;
                led_q   <= ~led_q;
                if (match_cnt_q != 8'hFF) match_cnt_q <= match_cnt_q + 8'd1;
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
            armed_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign armed     = armed_q;
  assign cfg_err   = cfg_err_q;
  assign match     = match_q;
  assign led       = led_q;
  assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_str_match_ctrl.sv
// tb/tb_str_match_ctrl.sv - self-checking bench for str_match_ctrl
// Queue-based reference model checked every cycle, plus directed literal checks.
module tb_str_match_ctrl;

  logic       clk_50mhz = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_data;
  logic [3:0] cfg_len;
  logic       cfg_commit;
  logic       disarm;
  logic [7:0] data;
  logic       data_vld;
  logic       armed;
  logic       cfg_err;
  logic       match;
  logic       led;
  logic [7:0] match_cnt;

  always #10 clk_50mhz = ~clk_50mhz;

  str_match_ctrl #(.MAX_LEN(8)) dut (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_len   (cfg_len),
    .cfg_commit(cfg_commit),
    .disarm    (disarm),
    .data      (data),
    .data_vld  (data_vld),
    .armed     (armed),
    .cfg_err   (cfg_err),
    .match     (match),
    .led       (led),
    .match_cnt (match_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;

  // Reference model: bytes consumed toward the current candidate match are kept in a queue.
  logic [7:0] m_pat [8];
  int         m_len = 0;
  logic       m_armed = 1'b0;
  logic       m_err = 1'b0;
  logic       m_match = 1'b0;
  int         m_total = 0;
  logic [7:0] m_part [$];
  bit         m_ok;

  initial for (int i = 0; i < 8; i++) m_pat[i] = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_pat[i] = 8'h00;
      m_len = 0; m_armed = 1'b0; m_err = 1'b0; m_match = 1'b0; m_total = 0;
      m_part.delete();
    end else begin
      m_match = 1'b0;
      if (!m_armed && cfg_we) m_pat[cfg_addr] = cfg_data;
      if (disarm) begin
        m_armed = 1'b0;
        m_part.delete();
      end else if (!m_armed) begin
        if (cfg_commit) begin
          if (cfg_len >= 1 && cfg_len <= 8) begin
            m_len = int'(cfg_len); m_err = 1'b0; m_armed = 1'b1;
            m_part.delete();
          end else begin
            m_err = 1'b1;
          end
        end
      end else if (data_vld) begin
        m_part.push_back(data);
        m_ok = 1'b1;
        foreach (m_part[i]) if (m_part[i] != m_pat[i]) m_ok = 1'b0;
        if (m_ok && m_part.size() == m_len) begin
          m_match = 1'b1;
          m_total++;
          m_part.delete();
        end else if (!m_ok) begin
          m_part.delete();
          if (data == m_pat[0]) m_part.push_back(data);
        end
      end
    end
  end

  always @(negedge clk_50mhz) begin
    if (rst_n === 1'b1) begin
      chk("armed", armed, m_armed);
      chk("cfg_err", cfg_err, m_err);
      chk("match", match, m_match);
      chk("led", led, m_total % 2);
      chk("match_cnt", match_cnt, (m_total > 255) ? 255 : m_total);
      if (match) pulses++;
    end
  end

  task automatic set_in(input logic we, input logic [2:0] a, input logic [7:0] d,
                        input logic [3:0] l, input logic c, input logic dis,
                        input logic [7:0] dt, input logic v);
    @(negedge clk_50mhz);
    #1;
    cfg_we = we; cfg_addr = a; cfg_data = d; cfg_len = l;
    cfg_commit = c; disarm = dis; data = dt; data_vld = v;
  endtask

  task automatic idle();                      set_in(0, a_zero(), 0, 0, 0, 0, 0, 0); endtask
  task automatic wr(input logic [2:0] a, input logic [7:0] d); set_in(1, a, d, 0, 0, 0, 0, 0); endtask
  task automatic commit(input logic [3:0] l); set_in(0, a_zero(), 0, l, 1, 0, 0, 0); endtask
  task automatic dis();                       set_in(0, a_zero(), 0, 0, 0, 1, 0, 0); endtask
  task automatic send(input logic [7:0] b);   set_in(0, a_zero(), 0, 0, 0, 0, b, 1); endtask

  function automatic logic [2:0] a_zero();
    return 3'd0;
  endfunction

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic load_hello();
    string s;
    s = "HELLO";
    for (int i = 0; i < 5; i++) wr(3'(i), s[i]);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_armed"}, armed, 0);
    chk({tag, "_err"}, cfg_err, 0);
    chk({tag, "_match"}, match, 0);
    chk({tag, "_led"}, led, 0);
    chk({tag, "_cnt"}, match_cnt, 0);
  endtask

  int p;

  initial begin
    rst_n = 1'b0;
    cfg_we = 0; cfg_addr = 0; cfg_data = 0; cfg_len = 0;
    cfg_commit = 0; disarm = 0; data = 0; data_vld = 0;
    #5;
    chk_zero("reset");
    @(negedge clk_50mhz); #1; rst_n = 1'b1;
    idle();

    // Basic HELLO match with a restart inside the stream
    load_hello();
    commit(5);
    idle();
    chk("hello_armed", armed, 1);
    p = pulses;
    send_str("HEHELL");
    send("O");
    idle();
    chk("hello_latency", match, 1);
    idle();
    chk("hello_width", match, 0);
    chk("hello_pulses", pulses - p, 1);
    chk("hello_cnt", match_cnt, 1);
    chk("hello_led", led, 1);

    p = pulses; send_str("HHELLO"); idle(); idle();
    chk("hhello_pulses", pulses - p, 1);
    p = pulses; send_str("HELHELLO"); idle(); idle();
    chk("helhello_pulses", pulses - p, 1);
    p = pulses; send_str("hello"); idle(); idle();
    chk("lower_pulses", pulses - p, 0);
    chk("after3_cnt", match_cnt, 3);
    chk("after3_led", led, 1);

    // Length validation
    dis();
    commit(0); idle();
    chk("len0_armed", armed, 0);
    chk("len0_err", cfg_err, 1);
    commit(9); idle();
    chk("len9_armed", armed, 0);
    chk("len9_err", cfg_err, 1);
    commit(5); idle();
    chk("len5_armed", armed, 1);
    chk("len5_err", cfg_err, 0);

    // Disarm abandons the partial match; pattern writes while running are ignored
    send_str("HEL");
    dis();
    commit(5);
    p = pulses; send_str("LO"); idle(); idle();
    chk("disarm_pulses", pulses - p, 0);
    wr(3'd0, 8'h58);
    p = pulses; send_str("HELLO"); idle(); idle();
    chk("runwe_pulses", pulses - p, 1);
    chk("after4_cnt", match_cnt, 4);
    chk("after4_led", led, 0);

    // Reset in the middle of a pattern
    send_str("HELL");
    @(posedge clk_50mhz); #5;
    rst_n = 1'b0; #1;
    chk_zero("rst_mid");
    @(negedge clk_50mhz); #1; rst_n = 1'b1;
    p = pulses; send("O"); idle(); idle();
    chk("rst_mid_pulses", pulses - p, 0);
    chk("rst_mid_armed", armed, 0);

    // Reset while the match pulse is high
    load_hello();
    commit(5);
    send_str("HELLO");
    @(posedge clk_50mhz); #2;
    chk("pulse_before_rst", match, 1);
    rst_n = 1'b0; #1;
    chk_zero("rst_pulse");
    @(negedge clk_50mhz); #1; rst_n = 1'b1;
    idle();

    // Single-byte pattern, gaps and back-to-back, saturation
    wr(3'd0, 8'h4C);
    commit(1);
    p = pulses;
    send(8'h4C); idle(); send(8'h4C); idle(); idle(); send(8'h4C); idle(); idle();
    chk("len1_pulses", pulses - p, 3);
    chk("len1_cnt", match_cnt, 3);
    chk("len1_led", led, 1);
    for (int i = 0; i < 257; i++) send(8'h4C);
    idle(); idle();
    chk("sat_pulses", pulses - p, 260);
    chk("sat_cnt", match_cnt, 255);
    chk("sat_led", led, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
